// File: rtl/mult_share_ctrl.sv
// Shares one sequential 16-bit multiplier among NREQ requesters.
// Define MULT_SHARE_RR_EN for round-robin; default is fixed priority.
module mult_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 17,
  parameter int RST_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [16*NREQ-1:0] req_x,
  input  logic [16*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [15:0]       rsp_data,
  output logic              busy,
  output logic [15:0]       mul_x,
  output logic [15:0]       mul_y,
  output logic              mul_reset,
  input  logic [15:0]       mul_out
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (MUL_LAT > RST_CYC) ? MUL_LAT : RST_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] CLR_LD = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] RUN_LD = CW'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   own_q, own_d;
  logic [15:0]     x_q, x_d;
  logic [15:0]     y_q, y_d;
  logic [15:0]     rd_q, rd_d;
  logic [IW-1:0]   grant;
  logic            gnt_vld;
  logic            xfer;

`ifdef MULT_SHARE_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   sum;
  logic [IW-1:0] ix;

  // Walk downwards so the candidate closest to the pointer wins.
  always_comb begin
    grant   = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    ix      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ))
        sum = sum - (IW+1)'(NREQ);
      ix = sum[IW-1:0];
      if (req_valid[ix]) begin
        grant   = ix;
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer)
      ptr_d = (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  logic [IW-1:0] ix;

  always_comb begin
    grant   = '0;
    gnt_vld = 1'b0;
    ix      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      ix = IW'(k);
      if (req_valid[ix]) begin
        grant   = ix;
        gnt_vld = 1'b1;
      end
    end
  end
`endif

  assign xfer = (state_q == IDLE) && gnt_vld && !reset;

  always_comb begin
    req_ready = '0;
    if (xfer)
      req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    x_d     = x_q;
    y_d     = y_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          x_d     = req_x[{grant, 4'b0000} +: 16];
          y_d     = req_y[{grant, 4'b0000} +: 16];
          own_d   = grant;
          cnt_d   = CLR_LD;
          state_d = CLR;
        end
      end
      CLR: begin
        if (cnt_q == '0) begin
          cnt_d   = RUN_LD;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          rd_d    = mul_out;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      own_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == DONE && !reset)
      rsp_valid[own_q] = 1'b1;
  end

  assign rsp_data  = rd_q;
  assign busy      = (state_q != IDLE);
  assign mul_x     = x_q;
  assign mul_y     = y_q;
  assign mul_reset = reset | (state_q == CLR);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a behavioural MULTIPLY model.
// Expected arbitration order follows MULT_SHARE_RR_EN.
module tb_mult_share_ctrl;
  localparam int NREQ    = 4;
  localparam int MUL_LAT = 17;
  localparam int RST_CYC = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_x, req_y;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic [15:0] mul_x, mul_y, mul_out;
  logic        mul_reset;

  int tests = 0;
  int fails = 0;

  mult_share_ctrl #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .mul_x(mul_x), .mul_y(mul_y), .mul_reset(mul_reset),
    .mul_out(mul_out)
  );

  always #5 clk = ~clk;

  // Multiplier model: product valid only in the MUL_LAT-th cycle after restart.
  logic [4:0]  mcnt;
  logic [31:0] prod;
  always_ff @(posedge clk) begin
    if (mul_reset) mcnt <= '0;
    else if (mcnt != 5'(MUL_LAT - 1)) mcnt <= mcnt + 1'b1;
  end
  always_comb begin
    prod    = 32'(mul_x) * 32'(mul_y);
    mul_out = (mcnt == 5'(MUL_LAT - 1) && !mul_reset) ? prod[15:0] : 16'hDEAD;
  end

  // Drives one request from the current negedge; returns measured response.
  task automatic run_job(input int r, input logic [15:0] x, input logic [15:0] y,
                         output bit rdy, output int lat, output logic [3:0] rv,
                         output logic [15:0] rd, output logic [1:0] mrst);
    req_x[r*16 +: 16] = x;
    req_y[r*16 +: 16] = y;
    req_valid[r] = 1'b1;
    #1;
    rdy = req_ready[r];
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    lat = -1; rv = '0; rd = '0; mrst = '0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) mrst[0] = mul_reset;
      else if (j == 1) mrst[1] = mul_reset;
      if (|rsp_valid) begin
        lat = j; rv = rsp_valid; rd = rsp_data;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 4'b0001;
    req_x = '0; req_y = '0;
    repeat (10) @(negedge clk);
    tests++;
    if (mul_reset !== 1'b1) begin fails++; $display("FAIL reset_mul_reset got %b want 1", mul_reset); end
    tests++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    tests++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin fails++; $display("FAIL reset_busy_rsp got %b/%b want 0/0000", busy, rsp_valid); end
    tests++;
    if (rsp_data !== 16'd0) begin fails++; $display("FAIL reset_rsp_data got %0d want 0", rsp_data); end
    tests++;
    if (mul_x !== 16'd0 || mul_y !== 16'd0) begin fails++; $display("FAIL reset_mul_xy got %0d/%0d want 0/0", mul_x, mul_y); end
    reset = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_first;
    bit rdy; int lat; logic [3:0] rv; logic [15:0] rd; logic [1:0] mr;
    @(negedge clk);
    run_job(0, 16'd3, 16'd2, rdy, lat, rv, rd, mr);
    tests++;
    if (rdy !== 1'b1) begin fails++; $display("FAIL first_ready got %b want 1", rdy); end
    tests++;
    if (lat !== 18) begin fails++; $display("FAIL first_latency got %0d want 18", lat); end
    tests++;
    if (rv !== 4'b0001) begin fails++; $display("FAIL first_rsp_valid got %b want 0001", rv); end
    tests++;
    if (rd !== 16'd6) begin fails++; $display("FAIL first_data got %0d want 6", rd); end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL first_busy_after got %b want 0", busy); end
    tests++;
    if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL first_pulse_width got %b want 0000", rsp_valid); end
  endtask

  task automatic test_req2;
    bit rdy; int lat; logic [3:0] rv; logic [15:0] rd; logic [1:0] mr;
    @(negedge clk);
    run_job(2, 16'd3, 16'd6, rdy, lat, rv, rd, mr);
    tests++;
    if (rdy !== 1'b1 || lat !== 18) begin fails++; $display("FAIL req2_timing got rdy=%b lat=%0d want 1/18", rdy, lat); end
    tests++;
    if (rv !== 4'b0100) begin fails++; $display("FAIL req2_rsp_valid got %b want 0100", rv); end
    tests++;
    if (rd !== 16'd18) begin fails++; $display("FAIL req2_data got %0d want 18", rd); end
    tests++;
    if (mr !== 2'b01) begin fails++; $display("FAIL req2_mul_reset_pulse got %b want 01", mr); end
  endtask

  task automatic test_overflow;
    bit rdy; int lat; logic [3:0] rv; logic [15:0] rd; logic [1:0] mr;
    @(negedge clk);
    run_job(1, 16'd300, 16'd300, rdy, lat, rv, rd, mr);
    tests++;
    if (rv !== 4'b0010) begin fails++; $display("FAIL ovf_rsp_valid got %b want 0010", rv); end
    tests++;
    if (rd !== 16'd24464) begin fails++; $display("FAIL ovf_data got %0d want 24464", rd); end
  endtask

  task automatic test_arbitration;
    int exp_own [4];
    logic [15:0] exp_dat [4];
    int t, last;
`ifdef MULT_SHARE_RR_EN
    exp_own = '{0, 1, 2, 3};
    exp_dat = '{16'd6, 16'd20, 16'd42, 16'd72};
`else
    exp_own = '{0, 0, 0, 0};
    exp_dat = '{16'd6, 16'd6, 16'd6, 16'd6};
`endif
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    req_x = {16'd8, 16'd6, 16'd4, 16'd2};
    req_y = {16'd9, 16'd7, 16'd5, 16'd3};
    req_valid = 4'hF;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL arb_ready got %b want 0001", req_ready); end
    t = 0; last = 0;
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        t++;
        if (|rsp_valid) break;
      end
      tests++;
      if (rsp_valid !== (4'b0001 << exp_own[n])) begin
        fails++; $display("FAIL arb_owner%0d got %b want %0d", n, rsp_valid, exp_own[n]);
      end
      tests++;
      if (rsp_data !== exp_dat[n]) begin
        fails++; $display("FAIL arb_data%0d got %0d want %0d", n, rsp_data, exp_dat[n]);
      end
      if (n > 0) begin
        tests++;
        if (t - last !== 20) begin fails++; $display("FAIL arb_gap%0d got %0d want 20", n, t - last); end
      end
      last = t;
    end
    req_valid = '0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL arb_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_midreset;
    bit rdy; int lat; logic [3:0] rv; logic [15:0] rd; logic [1:0] mr;
    @(negedge clk);
    req_x[31:16] = 16'd5; req_y[31:16] = 16'd7;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin fails++; $display("FAIL midrst_state got busy=%b rsp=%b want 0/0000", busy, rsp_valid); end
    tests++;
    if (rsp_data !== 16'd0) begin fails++; $display("FAIL midrst_rsp_data got %0d want 0", rsp_data); end
    run_job(3, 16'd9, 16'd11, rdy, lat, rv, rd, mr);
    tests++;
    if (rdy !== 1'b1) begin fails++; $display("FAIL midrst_accept got %b want 1", rdy); end
    tests++;
    if (lat !== 18 || rv !== 4'b1000) begin fails++; $display("FAIL midrst_rsp got lat=%0d rv=%b want 18/1000", lat, rv); end
    tests++;
    if (rd !== 16'd99) begin fails++; $display("FAIL midrst_data got %0d want 99", rd); end
  endtask

  task automatic test_busy_drop;
    int hits1;
    logic [3:0] rv;
    logic [15:0] rd;
    @(negedge clk);
    req_x[15:0] = 16'd4; req_y[15:0] = 16'd5;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    req_x[31:16] = 16'd1; req_y[31:16] = 16'd1;
    req_valid[1] = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL busy_ready got %b want 0000", req_ready); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    rv = '0; rd = '0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (|rsp_valid) begin rv = rsp_valid; rd = rsp_data; break; end
    end
    tests++;
    if (rv !== 4'b0001 || rd !== 16'd20) begin fails++; $display("FAIL busy_job got rv=%b data=%0d want 0001/20", rv, rd); end
    hits1 = 0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid[1] || busy) hits1++;
    end
    tests++;
    if (hits1 !== 0) begin fails++; $display("FAIL busy_no_req1 got %0d cycles want 0", hits1); end
  endtask

  initial begin
    test_reset();
    test_first();
    test_req2();
    test_overflow();
    test_arbitration();
    test_midreset();
    test_busy_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
